// File: rtl/mips_run_ctrl_if.sv
// Harness/core-observation bundle for the Lite MIPS run sequencer.
// master = harness side driving the controls, slave = the sequencer.
interface mips_run_ctrl_if #(
   parameter int CNT_W = 16
) ();
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] max_cycles;
   logic [29:0]      pc_current;
   logic [31:0]      opcode;
   logic             core_rst_n;
   logic             core_run;
   logic             busy;
   logic             done;
   logic [2:0]       halt_cause;
   logic [CNT_W-1:0] cycle_count;

   modport master (
      output start, abort, max_cycles, pc_current, opcode,
      input  core_rst_n, core_run, busy, done, halt_cause, cycle_count
   );

   modport slave (
      input  start, abort, max_cycles, pc_current, opcode,
      output core_rst_n, core_run, busy, done, halt_cause, cycle_count
   );
endinterface

// File: rtl/mips_run_ctrl.sv
// Run sequencer for the Lite MIPS core: primes the core under reset, runs it,
// and stops it on halt opcode, branch-to-self, cycle budget or abort.
//
// state | meaning
// IDLE  | after reset; core held in reset, not clocked
// PRIME | core clocked while held in reset for RST_CYCLES clocks
// RUN   | core executing; stop conditions checked every cycle
// DONE  | core frozen (out of reset, not clocked) for readout
module mips_run_ctrl #(
   parameter int          CNT_W       = 16,
   parameter int          RST_CYCLES  = 2,
   parameter logic [31:0] HALT_OPCODE = 32'h0000_000C
) (
   input logic            clk,
   input logic            rst,
   mips_run_ctrl_if.slave bus
);

   localparam int PRIME_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [PRIME_W-1:0] PRIME_LOAD = PRIME_W'(RST_CYCLES - 1);

   localparam logic [2:0] CAUSE_NONE   = 3'd0;
   localparam logic [2:0] CAUSE_HALT   = 3'd1;
   localparam logic [2:0] CAUSE_LOOP   = 3'd2;
   localparam logic [2:0] CAUSE_BUDGET = 3'd3;
   localparam logic [2:0] CAUSE_ABORT  = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [PRIME_W-1:0] prime_cnt, prime_cnt_nxt;
   logic [CNT_W-1:0] budget, budget_nxt;
   logic [CNT_W-1:0] cycle_count, cycle_count_nxt;
   logic [2:0]       halt_cause, halt_cause_nxt;
   logic [29:0]      pc_prev, pc_prev_nxt;
   logic             pc_prev_vld, pc_prev_vld_nxt;
   logic [CNT_W:0]   cnt_inc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         prime_cnt   <= '0;
         budget      <= '0;
         cycle_count <= '0;
         halt_cause  <= CAUSE_NONE;
         pc_prev     <= '0;
         pc_prev_vld <= 1'b0;
      end else begin
         state       <= state_nxt;
         prime_cnt   <= prime_cnt_nxt;
         budget      <= budget_nxt;
         cycle_count <= cycle_count_nxt;
         halt_cause  <= halt_cause_nxt;
         pc_prev     <= pc_prev_nxt;
         pc_prev_vld <= pc_prev_vld_nxt;
      end
   end

   // One extra bit so an all-ones count shows up as a carry, not a wrap to zero.
   assign cnt_inc = (CNT_W+1)'(cycle_count) + (CNT_W+1)'(1);

   always_comb begin
      state_nxt       = state;
      prime_cnt_nxt   = prime_cnt;
      budget_nxt      = budget;
      cycle_count_nxt = cycle_count;
      halt_cause_nxt  = halt_cause;
      pc_prev_nxt     = pc_prev;
      pc_prev_vld_nxt = pc_prev_vld;

      case (state)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               state_nxt       = ST_PRIME;
               prime_cnt_nxt   = PRIME_LOAD;
               budget_nxt      = bus.max_cycles;
               cycle_count_nxt = '0;
               halt_cause_nxt  = CAUSE_NONE;
               pc_prev_vld_nxt = 1'b0;
            end
         end
         ST_PRIME: begin
            if (bus.abort) begin
               state_nxt      = ST_DONE;
               halt_cause_nxt = CAUSE_ABORT;
            end else if (prime_cnt == '0) begin
               state_nxt = ST_RUN;
            end else begin
               prime_cnt_nxt = prime_cnt - PRIME_W'(1);
            end
         end
         ST_RUN: begin
            pc_prev_nxt     = bus.pc_current;
            pc_prev_vld_nxt = 1'b1;
            cycle_count_nxt = cnt_inc[CNT_W-1:0];
            if (bus.abort) begin
               state_nxt       = ST_DONE;
               halt_cause_nxt  = CAUSE_ABORT;
               cycle_count_nxt = cycle_count;
            end else if (bus.opcode == HALT_OPCODE) begin
               state_nxt      = ST_DONE;
               halt_cause_nxt = CAUSE_HALT;
            end else if (pc_prev_vld && (bus.pc_current == pc_prev)) begin
               state_nxt      = ST_DONE;
               halt_cause_nxt = CAUSE_LOOP;
            end else if ((budget != '0) && (cnt_inc == {1'b0, budget})) begin
               state_nxt      = ST_DONE;
               halt_cause_nxt = CAUSE_BUDGET;
            end else if ((budget == '0) && cnt_inc[CNT_W]) begin
               state_nxt       = ST_DONE;
               halt_cause_nxt  = CAUSE_BUDGET;
               cycle_count_nxt = cycle_count;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.core_rst_n = 1'b0;
      bus.core_run   = 1'b0;
      bus.busy       = 1'b0;
      bus.done       = 1'b0;
      case (state)
         ST_PRIME: begin
            bus.core_run = 1'b1;
            bus.busy     = 1'b1;
         end
         ST_RUN: begin
            bus.core_rst_n = 1'b1;
            bus.core_run   = 1'b1;
            bus.busy       = 1'b1;
         end
         ST_DONE: begin
            bus.core_rst_n = 1'b1;
            bus.done       = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.halt_cause  = halt_cause;
   assign bus.cycle_count = cycle_count;

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
Run sequencer for the Lite MIPS core. On a start request it holds the core in reset for a programmable number of clocks, then lets it execute. It stops the core on a halt opcode, a branch-to-self, a cycle budget or an abort, and reports the cause and the cycle count. It sits between the top-level harness and the core's clock-enable/reset inputs, and observes the core's pc_current and opcode.

Parameters:
CNT_W, 16, width of the cycle budget and the cycle counter
RST_CYCLES, 2, number of clocks the core is held in reset before RUN (must be at least 1)
HALT_OPCODE, 32'h0000000C, instruction word that terminates execution

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low (0 = reset)
start  input  1  one-cycle run request; accepted only in IDLE or DONE
abort  input  1  forced stop; effective only in PRIME or RUN
max_cycles  input  CNT_W  RUN-cycle budget, sampled when start is accepted; 0 = unlimited
pc_current  input  30  core word PC (bits 31:2)
opcode  input  32  instruction at pc_current, same cycle
core_rst_n  output  1  active-low reset to the core
core_run  output  1  clock enable to the core
busy  output  1  high in PRIME and RUN
done  output  1  high in DONE
halt_cause  output  3  0 none, 1 halt opcode, 2 self-loop, 3 budget/saturation, 4 abort
cycle_count  output  CNT_W  RUN cycles executed

Behaviour:
- Reset (rst=0, takes effect immediately, without a clock edge): state=IDLE, core_rst_n=0, core_run=0, busy=0, done=0, halt_cause=0, cycle_count=0, prime counter=0, pc_prev valid=0. Reset asserted mid-PRIME or mid-RUN forces these values at once.
- Outputs are decoded from registered state only (Moore). There is no combinational path from the inputs to the outputs.
- IDLE: core_rst_n=0, core_run=0.
  - start=1 causes, at the next edge: state→PRIME; prime counter←RST_CYCLES-1; budget register←max_cycles; cycle_count←0; halt_cause←0; pc_prev valid←0.
- PRIME: core_rst_n=0, core_run=1, so the core is clocked while held in reset.
  - Counter decrements each cycle.
  - Counter=0 → RUN at the next edge.
  - abort=1 → DONE with cause 4.
  - PRIME lasts exactly RST_CYCLES cycles.
- RUN: core_rst_n=1, core_run=1.
  - Checks are evaluated every cycle on the current inputs, in priority order:
    1. abort=1 → DONE, cause 4, cycle_count not incremented.
    2. opcode==HALT_OPCODE → DONE, cause 1.
    3. pc_prev valid and pc_current==pc_prev → DONE, cause 2.
    4. budget≠0 and cycle_count+1==budget → DONE, cause 3.
    5. budget==0 and cycle_count+1 wraps to 0 (saturation) → DONE, cause 3; cycle_count holds all-ones.
  - Causes 1–3 increment cycle_count in the detecting cycle. The detecting cycle's edge is applied to the core, because core_run is still 1.
  - Every RUN cycle: pc_prev←pc_current; pc_prev valid←1. The first RUN cycle never flags a self-loop, including when the last PC of PRIME equals the first PC of RUN.
- DONE: core_rst_n=1 and core_run=0, so core state and data memory are frozen for readout. done=1, busy=0.
  - halt_cause and cycle_count hold.
  - start=1 restarts exactly as from IDLE; done drops at the next edge.
- Ignored inputs:
  - start in PRIME or RUN.
  - abort in IDLE or DONE.
  - start and abort together in IDLE or DONE: start is taken and abort is ignored.
- Width rules: cycle_count is unsigned CNT_W bits. The budget compare uses cycle_count+1 computed at CNT_W+1 bits.

Test Plan:
1. RST_CYCLES=2, max_cycles=5, PC incrementing 0,1,2,…, no halt opcode, start pulse → 2 cycles of core_rst_n=0 with core_run=1, then exactly 5 cycles of core_run=1 with core_rst_n=1, then done=1, halt_cause=3, cycle_count=5, busy=0.
2. max_cycles=100, opcode=32'h0000000C on the 4th RUN cycle → DONE the next cycle, halt_cause=1, cycle_count=4.
3. PC 7,8,9,9 over RUN cycles 1–4, with PC=7 also on the last PRIME cycle → halt_cause=2, cycle_count=4; no self-loop flag on RUN cycle 1.
4. abort on RUN cycle 3 → halt_cause=4, cycle_count=2. Separately, abort during PRIME → halt_cause=4, cycle_count=0.
5. rst driven low asynchronously mid-RUN, between edges → all outputs take reset values before the next edge; rst released then start → normal sequence restarts with cycle_count from 0.
6. In DONE: start with max_cycles=0 (CNT_W=4 build) → unlimited run saturates, halt_cause=3, cycle_count=4'hF. Start pulsed during RUN → ignored, no restart, count continues.
